geo_cmd_arbiter: RTL and testbench
==================================

// Module: geo_cmd_arbiter
// PURPOSE
//  Shares the geometry processor's single 16-bit command input (fifo_cmd_in/fifo_cmd_ready/fifo_cmd_busy) between two sources:
//  src A = Z80 bus output port, src B = display-list fetcher. Packets are atomic: once a source is granted, it keeps the port
//  until it sends a word flagged last. Round-robin between packets. Words are buffered in a 1-entry hold register and strobed
//  into the geometry processor only while fifo_cmd_busy is low.
// PARAMETERS
//  MAX_PKT   default 16    max words per packet; the grant is force-released after MAX_PKT words even if 'last' is never seen
//  A_FIRST   default 1     after reset, the first contested packet goes to A (1) or B (0)
//  WD_CYCLES default 1024  watchdog idle limit in clocks (used only with GEO_ARB_WATCHDOG_EN)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  a_valid        in   1   src A word valid
//  a_data         in   16  src A command word
//  a_last         in   1   src A word ends packet
//  a_ready        out  1   src A word accepted this cycle
//  b_valid        in   1   src B word valid
//  b_data         in   16  src B command word
//  b_last         in   1   src B word ends packet
//  b_ready        out  1   src B word accepted this cycle
//  fifo_cmd_busy  in   1   geometry processor command FIFO full
//  fifo_cmd_ready out  1   one-cycle write strobe to the geometry processor
//  fifo_cmd_in    out  16  command word, valid while fifo_cmd_ready=1
//  owner          out  2   00 = none, 01 = A, 10 = B (current grant)
//  pkt_abort      out  1   one-cycle pulse when a grant is force-released
// BEHAVIOUR
//  Reset: all outputs 0; hold register empty; state IDLE; rr_last = A_FIRST ? B : A; word count 0.
//  FSM: IDLE -> OWN_A / OWN_B when the respective *_valid=1; both valid -> the source != rr_last.
//   OWN_x -> IDLE on an accepted word with x_last=1, or when the accepted-word count reaches MAX_PKT.
//   In the MAX_PKT case, pkt_abort pulses. rr_last <= x on every exit from OWN_x.
//   Grant decision is made in IDLE, so the first word of a packet is accepted the cycle after grant (1 idle cycle/packet).
//  Accept: x_ready = (state==OWN_x) && (!hold_v || drain), where drain = hold_v && !fifo_cmd_busy.
//   x_ready depends on x_valid only through the FSM; accept happens when x_valid && x_ready.
//  Output: fifo_cmd_ready = drain (combinational from hold_v and fifo_cmd_busy); fifo_cmd_in = hold_data.
//   Data reaches the output 1 clock after acceptance, or later while busy. Full throughput is 1 word/clk while busy=0.
//  Simultaneous drain+accept in the same cycle: hold_data is replaced, hold_v stays 1.
//  fifo_cmd_busy high: hold register keeps its word, no strobe, the source stalls. No word is dropped or duplicated.
//  Word counter: 0..MAX_PKT, clears on FSM exit; width = $clog2(MAX_PKT+1).
//  Inactive source: *_ready=0 regardless of *_valid. A source with valid=0 mid-packet keeps the grant (see watchdog).
//  owner: registered copy of the FSM state.
//  Reset mid-packet: the hold word is discarded and the FSM returns to IDLE. The geometry processor must be reset together with this block.
// CONFIGURATION
//  GEO_ARB_WATCHDOG_EN defined: a counter increments each cycle in OWN_x while x_valid=0 and clears on any accepted word.
//   When it reaches WD_CYCLES: pkt_abort pulses, FSM goes to IDLE, rr_last <= x.
//  GEO_ARB_WATCHDOG_EN undefined: no counter is built, and a stalled owner holds the grant indefinitely. WD_CYCLES is ignored.
// STRUCTURE
//  geo_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_OWN_A, ARB_OWN_B} arb_state_t; typedef enum logic [1:0] owner_t
//   (NONE=0, A=1, B=2); localparam CMD_W = 16.
//  Sub-module geo_cmd_hold: 1-entry hold register with load/drain/valid and the drain = v && !busy logic.
//  Arbiter FSM, counters and watchdog live in the top module.
// TESTING
//  1. A sends 3 words (0x1001,0x1002,0x1003 last), B idle, busy=0 -> strobes in order on clks 2,3,4 after a_valid; owner 01 then 00.
//  2. A and B both valid from reset, A_FIRST=1, each sends 2-word packets -> stream A,A,B,B,A,A; no interleave inside a packet.
//  3. busy=1 for 5 clks mid-packet -> exactly one word held, a_ready=0, no strobe;
//     on release the held word is strobed first, sequence unbroken.
//  4. B sends 20 words with last never set, MAX_PKT=16 -> pkt_abort after word 16;
//     A (pending) is granted next; B's 17th word goes out in B's next grant.
//  5. Reset asserted with a word held and FSM in OWN_B -> next clk: all outputs 0, owner 00, no strobe of the held word.
//  6. GEO_ARB_WATCHDOG_EN, WD_CYCLES=8: A sends 1 non-last word then drops valid, B valid -> pkt_abort 8 clks later, B granted.
//     Without the macro, A keeps the grant.

Source files
------------

// File: rtl/geo_cmd_arbiter_pkg.sv
// Shared types and widths for the geometry command arbiter.
package geo_arb_pkg;

  localparam int CMD_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_A = 2'd1,
    ARB_OWN_B = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    A    = 2'd1,
    B    = 2'd2
  } owner_t;

  // Owner code reported for a given arbiter state.
  function automatic owner_t state_owner(arb_state_t s);
    case (s)
      ARB_OWN_A: return A;
      ARB_OWN_B: return B;
      default:   return NONE;
    endcase
  endfunction

endpackage

// File: rtl/geo_cmd_arbiter_if.sv
// Source handshakes, geometry-processor command port and status of the arbiter.
interface geo_cmd_arbiter_if;
  import geo_arb_pkg::*;

  logic             a_valid;
  logic [CMD_W-1:0] a_data;
  logic             a_last;
  logic             a_ready;
  logic             b_valid;
  logic [CMD_W-1:0] b_data;
  logic             b_last;
  logic             b_ready;
  logic             fifo_cmd_busy;
  logic             fifo_cmd_ready;
  logic [CMD_W-1:0] fifo_cmd_in;
  logic [1:0]       owner;
  logic             pkt_abort;

  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, fifo_cmd_busy,
    input  a_ready, b_ready, fifo_cmd_ready, fifo_cmd_in, owner, pkt_abort
  );

  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, fifo_cmd_busy,
    output a_ready, b_ready, fifo_cmd_ready, fifo_cmd_in, owner, pkt_abort
  );

endinterface

// File: rtl/geo_cmd_arbiter_hold.sv
// One-entry hold register between the granted source and the geometry processor.
module geo_cmd_hold
  import geo_arb_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             load_i,
  input  logic [CMD_W-1:0] data_i,
  input  logic             busy_i,
  output logic             valid_o,
  output logic [CMD_W-1:0] data_o,
  output logic             drain_o
);

  logic             valid_q, valid_d;
  logic [CMD_W-1:0] data_q, data_d;

  // A load in the same cycle as a drain replaces the word and keeps the entry full.
  always_comb begin
    drain_o = valid_q && !busy_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/geo_cmd_arbiter.sv
// Packet-atomic round-robin arbiter sharing the geometry command port between sources A and B.
// Optional idle-owner watchdog is built when GEO_ARB_WATCHDOG_EN is defined.
module geo_cmd_arbiter
  import geo_arb_pkg::*;
#(
  parameter int MAX_PKT   = 16,
  parameter bit A_FIRST   = 1'b1,
  parameter int WD_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  geo_cmd_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_PKT + 1);

  arb_state_t       state_q, state_d;
  owner_t           rr_last_q, rr_last_d;
  owner_t           owner_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  logic             hold_v, drain, room;
  logic [CMD_W-1:0] hold_data, load_data;
  logic             own_valid, own_last, accept, cnt_full, wd_fire;

  assign room      = !hold_v || drain;
  assign own_valid = (state_q == ARB_OWN_A) ? bus.a_valid :
                     (state_q == ARB_OWN_B) ? bus.b_valid : 1'b0;
  assign own_last  = (state_q == ARB_OWN_B) ? bus.b_last : bus.a_last;
  assign load_data = (state_q == ARB_OWN_B) ? bus.b_data : bus.a_data;
  assign accept    = own_valid && room;
  assign cnt_full  = (cnt_q == CNT_W'(MAX_PKT - 1));

  assign bus.a_ready = (state_q == ARB_OWN_A) && room;
  assign bus.b_ready = (state_q == ARB_OWN_B) && room;

  geo_cmd_hold u_hold (
    .clk     (clk),
    .srst    (reset),
    .load_i  (accept),
    .data_i  (load_data),
    .busy_i  (bus.fifo_cmd_busy),
    .valid_o (hold_v),
    .data_o  (hold_data),
    .drain_o (drain)
  );

`ifdef GEO_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Counts idle cycles of the current owner; restarts on every accepted word.
  always_comb begin
    wd_d    = wd_q;
    wd_fire = 1'b0;
    if (state_q == ARB_IDLE || accept) begin
      wd_d = '0;
    end else if (!own_valid) begin
      if (wd_q == WD_W'(WD_CYCLES - 1)) begin
        wd_fire = 1'b1;
        wd_d    = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  // No watchdog: a stalled owner keeps the grant; the limit parameter has no effect.
  assign wd_fire = (WD_CYCLES < 0);
`endif

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.a_valid && bus.b_valid)
          state_d = (rr_last_q == A) ? ARB_OWN_B : ARB_OWN_A;
        else if (bus.a_valid)
          state_d = ARB_OWN_A;
        else if (bus.b_valid)
          state_d = ARB_OWN_B;
      end
      default: begin
        if (accept)
          cnt_d = cnt_q + 1'b1;
        if ((accept && (own_last || cnt_full)) || wd_fire) begin
          state_d   = ARB_IDLE;
          cnt_d     = '0;
          rr_last_d = (state_q == ARB_OWN_A) ? A : B;
          abort_d   = wd_fire || !own_last;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      rr_last_q <= A_FIRST ? B : A;
      owner_q   <= NONE;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= state_owner(state_d);
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.fifo_cmd_ready = drain;
  assign bus.fifo_cmd_in    = hold_data;
  assign bus.owner          = owner_q;
  assign bus.pkt_abort      = abort_q;

endmodule

// File: tb/tb_geo_cmd_arbiter.sv
// Directed and randomized checks of geo_cmd_arbiter against a packet-level scoreboard.
module tb_geo_cmd_arbiter;

  localparam int MAXP = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  geo_cmd_arbiter_if bus();

  geo_cmd_arbiter #(
    .MAX_PKT   (MAXP),
    .A_FIRST   (1'b1),
    .WD_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  logic [16:0] qa[$];
  logic [16:0] qb[$];
  logic [15:0] exp_q[$];
  logic [15:0] log_q[$];
  int  pa = 100, pb = 100, pbusy = 0;
  bit  acc_a = 0, acc_b = 0;
  bit  chk_pkt = 1;
  int  abort_cnt = 0;
  int  seq_a = 1, seq_b = 1;
  int  pushed = 0;
  bit  pkt_open = 0, pkt_src = 0, exp_abort = 0;
  int  pkt_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted words must leave in order through a single-entry hold,
  // packets must not interleave, and an over-long packet must be aborted.
  always @(negedge clk) begin : mon
    bit          src;
    logic [15:0] d;
    logic        l;
    if (reset) begin
      exp_q.delete();
      pkt_open  = 0;
      exp_abort = 0;
      acc_a     = 0;
      acc_b     = 0;
    end else begin
      if (chk_pkt) chk("pkt_abort", bus.pkt_abort, exp_abort);
      exp_abort = 0;
      if (bus.pkt_abort) abort_cnt++;
      if (bus.a_ready) chk("ready_a_owner", bus.owner, 2'd1);
      if (bus.b_ready) chk("ready_b_owner", bus.owner, 2'd2);
      if (bus.fifo_cmd_busy) chk("busy_no_strobe", bus.fifo_cmd_ready, 1'b0);
      if (exp_q.size() > 0) chk("hold_word", bus.fifo_cmd_in, exp_q[0]);
      if (bus.fifo_cmd_ready) begin
        log_q.push_back(bus.fifo_cmd_in);
        chk("hold_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      if (acc_a || acc_b) begin
        src = acc_b;
        d   = acc_b ? bus.b_data : bus.a_data;
        l   = acc_b ? bus.b_last : bus.a_last;
        exp_q.push_back(d);
        if (chk_pkt) begin
          if (pkt_open) chk("atomic_src", src, pkt_src);
          else begin
            pkt_open = 1;
            pkt_src  = src;
            pkt_cnt  = 0;
          end
          pkt_cnt++;
          if (l || pkt_cnt == MAXP) begin
            pkt_open  = 0;
            exp_abort = !l;
          end
        end
      end
    end
  end

  task automatic push_pkt(input bit src, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      logic lst;
      lst = with_last && (i == n - 1);
      if (src) begin
        qb.push_back({lst, 16'h8000 + 16'(seq_b)});
        seq_b++;
      end else begin
        qa.push_back({lst, 16'h1000 + 16'(seq_a)});
        seq_a++;
      end
      pushed++;
    end
  endtask

  task automatic cycle();
    bit ka, kb;
    @(posedge clk);
    #1;
    ka = acc_a;
    kb = acc_b;
    acc_a = 0;
    acc_b = 0;
    if (ka && qa.size() > 0) void'(qa.pop_front());
    if (kb && qb.size() > 0) void'(qb.pop_front());
    if (qa.size() == 0) bus.a_valid = 1'b0;
    else if (ka || !bus.a_valid) bus.a_valid = ($urandom_range(99) < pa);
    if (qb.size() == 0) bus.b_valid = 1'b0;
    else if (kb || !bus.b_valid) bus.b_valid = ($urandom_range(99) < pb);
    if (qa.size() > 0) {bus.a_last, bus.a_data} = qa[0];
    else {bus.a_last, bus.a_data} = 17'h0;
    if (qb.size() > 0) {bus.b_last, bus.b_data} = qb[0];
    else {bus.b_last, bus.b_data} = 17'h0;
    bus.fifo_cmd_busy = ($urandom_range(99) < pbusy);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    qa.delete();
    qb.delete();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.fifo_cmd_busy = 1'b0;
    pa = 100;
    pb = 100;
    pbusy = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    abort_cnt = 0;
    log_q.delete();
  endtask

  task automatic drain_wait(input string tag, input int lim);
    bit done;
    done = 0;
    for (int i = 0; i < lim && !done; i++) begin
      cycle();
      done = (qa.size() == 0) && (qb.size() == 0) && (exp_q.size() == 0) &&
             !bus.a_valid && !bus.b_valid;
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    int bfirst, afirst;
    bus.a_valid = 0; bus.a_data = 0; bus.a_last = 0;
    bus.b_valid = 0; bus.b_data = 0; bus.b_last = 0;
    bus.fifo_cmd_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_owner", bus.owner, 2'd0);
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_b_ready", bus.b_ready, 1'b0);
    chk("rst_strobe", bus.fifo_cmd_ready, 1'b0);
    chk("rst_data", bus.fifo_cmd_in, 16'h0);
    chk("rst_abort", bus.pkt_abort, 1'b0);
    reset = 1'b0;
    $display("reset state checked");

    // A alone, three words, no backpressure
    push_pkt(0, 3, 1);
    cycle();
    cycle();
    chk("t1_owner_grant", bus.owner, 2'd1);
    chk("t1_no_strobe_yet", bus.fifo_cmd_ready, 1'b0);
    cycle();
    chk("t1_strobe1", bus.fifo_cmd_ready, 1'b1);
    chk("t1_word1", bus.fifo_cmd_in, 16'h1001);
    cycle();
    chk("t1_word2", bus.fifo_cmd_in, 16'h1002);
    chk("t1_owner_mid", bus.owner, 2'd1);
    cycle();
    chk("t1_word3", bus.fifo_cmd_in, 16'h1003);
    chk("t1_owner_end", bus.owner, 2'd0);
    cycle();
    chk("t1_strobe_end", bus.fifo_cmd_ready, 1'b0);
    $display("t1 single packet: %0d words strobed", log_q.size());

    // Both sources contend with 2-word packets
    do_reset();
    push_pkt(0, 2, 1); push_pkt(0, 2, 1);
    push_pkt(1, 2, 1); push_pkt(1, 2, 1);
    drain_wait("t2_timeout", 80);
    chk("t2_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk($sformatf("t2_src%0d", i), log_q[i][15], ((i / 2) % 2 == 1));
    $display("t2 round robin: %0d words", log_q.size());

    // Backpressure mid-packet
    do_reset();
    afirst = seq_a;
    push_pkt(0, 6, 1);
    repeat (4) cycle();
    pbusy = 100;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_busy_strobe", bus.fifo_cmd_ready, 1'b0);
      chk("t3_busy_ready", bus.a_ready, 1'b0);
    end
    pbusy = 0;
    drain_wait("t3_timeout", 40);
    chk("t3_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      chk($sformatf("t3_word%0d", i), log_q[i], 16'h1000 + 16'(afirst + i));
    $display("t3 busy stall: %0d words", log_q.size());

    // Over-long B packet is cut at MAX_PKT and A gets the next grant
    do_reset();
    bfirst = seq_b;
    push_pkt(1, 20, 0);
    repeat (3) cycle();
    push_pkt(0, 2, 1);
    for (int i = 0; i < 80 && log_q.size() < 22; i++) cycle();
    chk("t4_count", log_q.size(), 22);
    chk("t4_aborts", abort_cnt, 1);
    if (log_q.size() >= 19) begin
      chk("t4_a_after_abort0", log_q[16][15], 1'b0);
      chk("t4_a_after_abort1", log_q[17][15], 1'b0);
      chk("t4_b17", log_q[18], 16'h8000 + 16'(bfirst + 16));
    end
    $display("t4 max packet abort: %0d aborts", abort_cnt);

    // Reset while B owns the port with a word held
    do_reset();
    push_pkt(1, 5, 1);
    repeat (3) cycle();
    pbusy = 100;
    repeat (3) cycle();
    chk("t5_owner_b", bus.owner, 2'd2);
    chk("t5_held_no_strobe", bus.fifo_cmd_ready, 1'b0);
    reset = 1'b1;
    qb.delete();
    bus.b_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.fifo_cmd_busy = 1'b0;
    pbusy = 0;
    #1;
    chk("t5_owner", bus.owner, 2'd0);
    chk("t5_strobe", bus.fifo_cmd_ready, 1'b0);
    chk("t5_data", bus.fifo_cmd_in, 16'h0);
    chk("t5_b_ready", bus.b_ready, 1'b0);
    chk("t5_abort", bus.pkt_abort, 1'b0);
    reset = 1'b0;
    log_q.delete();
    repeat (5) cycle();
    chk("t5_no_late_strobe", log_q.size(), 0);
    $display("t5 reset mid-packet checked");

    // Owner goes quiet mid-packet while B waits
    do_reset();
    chk_pkt = 0;
    bfirst = seq_b;
    push_pkt(0, 1, 0);
    push_pkt(1, 2, 1);
    repeat (30) cycle();
`ifdef GEO_ARB_WATCHDOG_EN
    chk("t6_wd_aborts", abort_cnt, 1);
    chk("t6_wd_count", log_q.size(), 3);
    if (log_q.size() >= 2) chk("t6_wd_b_granted", log_q[1], 16'h8000 + 16'(bfirst));
`else
    chk("t6_aborts", abort_cnt, 0);
    chk("t6_owner_kept", bus.owner, 2'd1);
    chk("t6_count", log_q.size(), 1);
`endif
    $display("t6 stalled owner: %0d aborts, %0d words", abort_cnt, log_q.size());
    do_reset();
    chk_pkt = 1;

    // Randomized traffic with random backpressure
    pa = 60; pb = 60; pbusy = 30;
    pushed = 0;
    for (int c = 0; c < 2000; c++) begin
      if (qa.size() < 3) push_pkt(0, ($urandom_range(9) == 0) ? 18 : $urandom_range(1, 5), 1);
      if (qb.size() < 3) push_pkt(1, ($urandom_range(9) == 0) ? 18 : $urandom_range(1, 5), 1);
      cycle();
    end
    pbusy = 20;
    drain_wait("rand_timeout", 600);
    chk("rand_conserved", log_q.size(), pushed);
    chk("rand_hold_empty", exp_q.size(), 0);
    $display("random: %0d words pushed, %0d strobed, %0d aborts", pushed, log_q.size(), abort_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
